uart_rx_os: RTL and testbench
=============================

# uart_rx_os

Oversampling UART receiver front-end that sits directly upstream of the byte-level UART logic. It owns baud timing: a programmable 16x oversample tick from a 12-bit divisor, rxd synchronisation, mid-bit majority-vote sampling, start/stop validation and error flagging. Received bytes go into a small FIFO that downstream logic drains with a valid/ready handshake.

## Interface
- FIFO_DEPTH, 4, entries in the output FIFO; must be a power of 2 and at least 2.
- PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- ubrr  in  12  divisor; one oversample tick every ubrr+1 clk cycles.
- rxd  in  1  asynchronous serial line; idle level is 1.
- data_o  out  8  byte at the FIFO head.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when high together with valid_o.
- busy  out  1  receiver FSM is not in IDLE.
- frame_err  out  1  one-cycle pulse when a stop bit is sampled as 0.
- overrun  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
- parity_err  out  1  one-cycle pulse on a parity mismatch; constant 0 without the macro.

## Operation
- **Synchroniser:** rxd passes through 2 flip-flops, both reset to 1, giving rxd_s. No logic reads raw rxd.
- **Tick generator:** a 12-bit down-counter reloads to ubrr when it reaches 0; tick = (counter == 0).
  - ubrr = 0 gives a tick every cycle.
  - A change to ubrr takes effect at the next reload.
- **Bit timing:** each bit lasts 16 ticks, tracked by a 4-bit os_cnt (0..15).
  - rxd_s is sampled at os_cnt 7, 8 and 9.
  - The bit value is the majority of the 3 samples, decided at os_cnt 9.
  - The bit period ends at os_cnt 15.
- **FSM states:** IDLE, START, DATA, PARITY (only with the macro), STOP, BREAK.
  - IDLE: on a tick with rxd_s == 0, go to START with os_cnt = 1.
  - START: at the os_cnt 9 decision, a majority of 1 is a false start and returns to IDLE. Otherwise, at os_cnt 15 go to DATA with bit_idx = 0.
  - DATA: shift in LSB first, one bit per 16 ticks. After bit 7 ends, go to PARITY if compiled in, otherwise STOP.
  - PARITY: check the decided bit against the data parity. Mismatch pulses parity_err and marks the byte bad. Always continue to STOP.
  - STOP, decision at os_cnt 9:
    - Stop bit 1 and byte good: push to the FIFO, go to IDLE.
    - Stop bit 1 and byte bad: discard, go to IDLE.
    - Stop bit 0: pulse frame_err, discard, go to BREAK.
  - BREAK: wait for rxd_s == 1 on a tick, then go to IDLE. This stops a held-low line from retriggering.
- **FIFO:** circular buffer with a count register.
  - data_o = mem[rd_ptr]; valid_o = (count != 0).
  - Pop when valid_o && ready_i.
  - Push while full with no pop in the same cycle: the byte is dropped, overrun pulses, and FIFO contents are unchanged.
  - Push and pop in the same cycle, full or not: both happen and count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- **busy** = (state != IDLE).

## Timing
- **Reset values:** data_o = 0x00; valid_o, busy, frame_err, overrun, parity_err = 0. FSM in IDLE, FIFO empty, tick counter = 0, os_cnt = 0.
- **Reset mid-frame:** the partial byte is lost and FIFO contents are cleared.
- **Synchroniser latency:** 2 clk from an rxd edge to rxd_s.
- **Push latency:** valid_o rises on the clk edge after the STOP os_cnt 9 decision tick, i.e. registered push.
- **Error pulses:** frame_err, parity_err and overrun are registered and high for exactly 1 clk.
- **Frame length at ubrr = 0:**
  - 1 start + 8 data + stop decision = 9.5 bit periods ≈ 153 clk from the falling edge to the push.
  - Add 16 clk when parity is compiled in.
- **data_o stability:** data_o stays stable while valid_o && !ready_i.

## Configuration
- **UART_RX_PARITY_EN defined:**
  - The PARITY state exists and one parity bit is expected between data and stop.
  - Parity sense comes from PARITY_ODD.
  - parity_err is live.
- **UART_RX_PARITY_EN undefined:**
  - Frame is 8N1 with no PARITY state.
  - parity_err is tied to 0.

## Test plan
- **Single byte:** ubrr = 0, send 8N1 0x55 at 16 clk/bit, ready_i = 1 → one valid_o cycle with data_o = 0x55; frame_err = 0; busy falls after the stop decision.
- **Glitch rejection:** drive rxd low for 4 clk, then high → no frame accepted, valid_o stays 0, and busy returns to 0 within 16 ticks.
- **Framing error:** send 0xA3 with stop = 0 and hold rxd low for 40 clk, then send 0x3C correctly → one frame_err pulse, 0xA3 not pushed, then data_o = 0x3C valid.
- **Overrun:** FIFO_DEPTH = 4, ready_i = 0, send 0x01..0x05 → 5th byte raises one overrun pulse; then assert ready_i → bytes pop in order 0x01, 0x02, 0x03, 0x04, then valid_o = 0.
- **Divisor:** ubrr = 3, send 0xF0 at 64 clk/bit → data_o = 0xF0; ±3% bit-rate skew is still received correctly.
- **Parity (macro defined, PARITY_ODD = 0):** send 0x07 with parity 1 → accepted; send 0x07 with parity 0 → parity_err pulse and no push. Reset mid-frame → all outputs 0, and the next frame 0x5A is received correctly.

Source files
------------

// File: rtl/uart_rx_os.sv
`timescale 1ns/1ps
// uart_rx_os: 16x oversampling UART receiver with majority-vote sampling and a small output FIFO.
// Latency: 2 clk rxd synchroniser; a byte is pushed on the clk after the stop-bit decision tick.
// Backpressure: valid/ready drain; a good byte arriving while the FIFO is full is dropped and flagged by overrun.
// Optional parity bit is compiled in with `define UART_RX_PARITY_EN (sense from PARITY_ODD).
module uart_rx_os #(
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_ODD = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] ubrr,
  input  logic        rxd,
  output logic [7:0]  data_o,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        busy,
  output logic        frame_err,
  output logic        overrun,
  output logic        parity_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  logic        sync1, rxd_s;
  logic [11:0] tcnt;
  logic        tick;

  state_t      state_q, state_d;
  logic [3:0]  os_q, os_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  sh_q, sh_d;
  logic [1:0]  samp_q, samp_d;
  logic        bad_q, bad_d;
  logic        maj;
  logic        push, ferr, perr;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [PTR_W:0]   count;
  logic             do_pop, do_push, full;

  // Two-flop synchroniser; idle-high reset so a reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync1 <= rxd;
      rxd_s <= sync1;
    end
  end

  // Oversample tick: down-counter reloading from ubrr, so a new divisor lands at the next reload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      tcnt <= 12'd0;
    else if (tcnt == 12'd0)
      tcnt <= ubrr;
    else
      tcnt <= tcnt - 12'd1;
  end

  assign tick = (tcnt == 12'd0);

  // Majority of the samples taken at os_cnt 7, 8 and the live sample at os_cnt 9.
  assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxd_s) | (samp_q[1] & rxd_s);

  // FSM state and bit-timing registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      os_q    <= 4'd0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      samp_q  <= 2'b11;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      os_q    <= os_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      samp_q  <= samp_d;
      bad_q   <= bad_d;
    end
  end

  // Next-state logic; everything advances only on oversample ticks.
  always_comb begin
    state_d = state_q;
    os_d    = os_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    samp_d  = samp_q;
    bad_d   = bad_q;
    push    = 1'b0;
    ferr    = 1'b0;
    perr    = 1'b0;
    if (tick) begin
      if (state_q != S_IDLE && state_q != S_BREAK) begin
        os_d = os_q + 4'd1;
        if (os_q == 4'd7) samp_d[0] = rxd_s;
        if (os_q == 4'd8) samp_d[1] = rxd_s;
      end
      case (state_q)
        S_IDLE: begin
          if (!rxd_s) begin
            state_d = S_START;
            os_d    = 4'd1;
            bad_d   = 1'b0;
          end
        end
        S_START: begin
          if (os_q == 4'd9 && maj) begin
            state_d = S_IDLE;
            os_d    = 4'd0;
          end else if (os_q == 4'd15) begin
            state_d = S_DATA;
            bit_d   = 3'd0;
          end
        end
        S_DATA: begin
          if (os_q == 4'd9) sh_d = {maj, sh_q[7:1]};
          if (os_q == 4'd15) begin
            if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_d = S_PARITY;
`else
              state_d = S_STOP;
`endif
            end else begin
              bit_d = bit_q + 3'd1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (os_q == 4'd9 && (maj != ((^sh_q) ^ PARITY_ODD))) begin
            perr  = 1'b1;
            bad_d = 1'b1;
          end
          if (os_q == 4'd15) state_d = S_STOP;
        end
`endif
        S_STOP: begin
          if (os_q == 4'd9) begin
            os_d = 4'd0;
            if (maj) begin
              push    = !bad_q;
              state_d = S_IDLE;
            end else begin
              ferr    = 1'b1;
              state_d = S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (rxd_s) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign full    = (count == FULL_CNT);
  assign valid_o = (count != '0);
  assign do_pop  = valid_o && ready_i;
  assign do_push = push && (!full || do_pop);
  assign data_o  = mem[rd_ptr];
  assign busy    = (state_q != S_IDLE);

  // Output FIFO: circular buffer with an occupancy count; contents cleared on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= sh_q;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Registered single-cycle error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= ferr;
      overrun   <= push && full && !do_pop;
    end
  end

`ifdef UART_RX_PARITY_EN
  // Registered parity mismatch pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      parity_err <= 1'b0;
    else
      parity_err <= perr;
  end
`else
  // No parity bit in the frame: the flag is constant; PARITY_ODD only matters with parity compiled in.
  assign parity_err = 1'b0 & PARITY_ODD;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
`timescale 1ns/1ps
// Bench for uart_rx_os: table of frames plus hand-written corner sequences.
// Expected bytes are queued as frames are driven and compared as the FIFO is drained.
// Error pulses are counted by a monitor and checked against per-sequence expectations.
module tb_uart_rx_os;

  logic        clk;
  logic        rst;
  logic [11:0] ubrr;
  logic        rxd;
  logic [7:0]  data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy;
  logic        frame_err;
  logic        overrun;
  logic        parity_err;

  int total = 0;
  int bad   = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int perr_cnt = 0;
  logic [7:0] exp_q [$];

  uart_rx_os #(.FIFO_DEPTH(4), .PARITY_ODD(1'b0)) dut (
    .clk(clk), .rst(rst), .ubrr(ubrr), .rxd(rxd),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ubrr;
    logic [7:0]  dat;
    logic        stop;
    int          cpb;
    logic        exp_push;
    int          exp_ferr;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int cpb, input logic par_bit);
    rxd = 1'b0;
    clks(cpb);
    for (int i = 0; i < 8; i++) begin
      rxd = d[i];
      clks(cpb);
    end
`ifdef UART_RX_PARITY_EN
    rxd = par_bit;
    clks(cpb);
`else
    if (par_bit === 1'bx) rxd = 1'b1;
`endif
    rxd = stop_b;
    clks(cpb);
    if (!stop_b) clks(40);
    rxd = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    #2;
    check(name, exp_q.size(), 0);
  endtask

  // Scoreboard and pulse monitor, sampled away from the active edge.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (frame_err)  ferr_cnt++;
      if (overrun)    ovr_cnt++;
      if (parity_err) perr_cnt++;
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_pop: got %0h expected no data", data_o);
        end else begin
          e = exp_q.pop_front();
          check("pop_data", data_o, e);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int f0, o0, p0;
    vecs[0] = '{12'd0, 8'h55, 1'b1, 16, 1'b1, 0};
    vecs[1] = '{12'd0, 8'h00, 1'b1, 16, 1'b1, 0};
    vecs[2] = '{12'd0, 8'hFF, 1'b1, 16, 1'b1, 0};
    vecs[3] = '{12'd0, 8'hA3, 1'b0, 16, 1'b0, 1};
    vecs[4] = '{12'd0, 8'h3C, 1'b1, 16, 1'b1, 0};
    vecs[5] = '{12'd3, 8'hF0, 1'b1, 64, 1'b1, 0};
    vecs[6] = '{12'd3, 8'h96, 1'b1, 62, 1'b1, 0};
    vecs[7] = '{12'd3, 8'h69, 1'b1, 66, 1'b1, 0};

    rst = 1'b0;
    ubrr = 12'd0;
    rxd = 1'b1;
    ready_i = 1'b0;
    clks(3);
    check("rst_data", data_o, 8'h00);
    check("rst_valid", valid_o, 0);
    check("rst_busy", busy, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_perr", parity_err, 0);
    rst = 1'b1;
    clks(5);

    // Table-driven frames.
    for (int v = 0; v < 8; v++) begin
      ubrr = vecs[v].ubrr;
      ready_i = 1'b1;
      f0 = ferr_cnt;
      clks(8);
      if (vecs[v].exp_push) exp_q.push_back(vecs[v].dat);
      send_frame(vecs[v].dat, vecs[v].stop, vecs[v].cpb, ^vecs[v].dat);
      clks(2 * vecs[v].cpb);
      drain($sformatf("vec%0d_drain", v));
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_busy", v), busy, 0);
    end

    // Glitch rejection.
    ubrr = 12'd0;
    clks(10);
    rxd = 1'b0;
    clks(4);
    rxd = 1'b1;
    check("glitch_busy_rise", busy, 1);
    clks(20);
    check("glitch_busy_fall", busy, 0);
    check("glitch_valid", valid_o, 0);

    // Overrun with a depth-4 FIFO held by ready_i = 0.
    ready_i = 1'b0;
    o0 = ovr_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 16, ^(8'(k)));
      clks(4);
    end
    clks(20);
    check("ovr_pulses", ovr_cnt - o0, 1);
    check("ovr_head_hold", data_o, 8'h01);
    for (int k = 1; k <= 4; k++) exp_q.push_back(8'(k));
    ready_i = 1'b1;
    drain("ovr_drain");
    clks(3);
    check("ovr_empty", valid_o, 0);

    // Reset mid-frame clears a held byte and the partial frame.
    ready_i = 1'b0;
    send_frame(8'h11, 1'b1, 16, ^(8'h11));
    clks(4);
    check("pre_rst_data", data_o, 8'h11);
    rxd = 1'b0;
    clks(40);
    check("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #3;
    check("mid_rst_data", data_o, 8'h00);
    check("mid_rst_valid", valid_o, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_errs", {frame_err, overrun, parity_err}, 0);
    rxd = 1'b1;
    clks(3);
    rst = 1'b1;
    clks(5);
    ready_i = 1'b1;
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1, 16, ^(8'h5A));
    clks(20);
    drain("post_rst_drain");

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 has odd weight, so a parity bit of 1 is correct.
    p0 = perr_cnt;
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 16, 1'b1);
    clks(20);
    drain("par_good_drain");
    check("par_good_perr", perr_cnt - p0, 0);
    send_frame(8'h07, 1'b1, 16, 1'b0);
    clks(20);
    check("par_bad_perr", perr_cnt - p0, 1);
    check("par_bad_valid", valid_o, 0);
`else
    p0 = 0;
    check("perr_never", perr_cnt - p0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
